// File: rtl/pvr_pkg.sv
// Shared definitions for the tile walker: tile geometry, coordinate widths,
// walker FSM states and the output pixel record.
package pvr_pkg;

    localparam int TILE_DIM   = 32;
    localparam int TILE_SHIFT = 5;
    localparam int COORD_W    = 11;
    localparam int TILE_IDX_W = COORD_W - TILE_SHIFT;
    localparam int Z_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WALK,
        ST_SETTLE,
        ST_DRAIN
    } walk_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [Z_W-1:0]     z;
        logic               last;
    } pix_t;

endpackage

// File: rtl/pvr_pix_outreg.sv
// One-entry valid/ready output register for walker pixels. cap_ok_o tells the
// producer the slot is free this cycle (empty, or being drained).
module pvr_pix_outreg
    import pvr_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic load_i,
    input  pix_t data_i,
    output logic cap_ok_o,
    output logic valid_o,
    input  logic ready_i,
    output pix_t data_o
);

    logic valid_q, valid_d;
    pix_t data_q, data_d;

    assign cap_ok_o = !valid_q || ready_i;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the payload is reset too, because downstream can observe pix_x/pix_y/pix_z while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pvr_tile_walker.sv
// Walks one 32x32 tile row-major through the plane interpolator and streams the
// samples out. Optional counters under PVR_TILE_WALKER_PERF_EN.
module pvr_tile_walker
    import pvr_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [TILE_IDX_W-1:0] tile_x,
    input  logic [TILE_IDX_W-1:0] tile_y,
    output logic                  setup,
    output logic [COORD_W-1:0]    x_ps,
    output logic [COORD_W-1:0]    y_ps,
    input  logic signed [Z_W-1:0] interp_in,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [COORD_W-1:0]    pix_x,
    output logic [COORD_W-1:0]    pix_y,
    output logic signed [Z_W-1:0] pix_z,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done
`ifdef PVR_TILE_WALKER_PERF_EN
    ,
    output logic [10:0]           perf_pix,
    output logic [15:0]           perf_stall
`endif
);

    localparam logic [TILE_SHIFT-1:0] OFS_MAX    = TILE_SHIFT'(TILE_DIM - 1);
    localparam logic [3:0]            SETUP_LAST = 4'(SETUP_CYCLES - 1);

    walk_state_e           state_q, state_d;
    logic [TILE_IDX_W-1:0] tile_x_q, tile_x_d, tile_y_q, tile_y_d;
    logic [TILE_SHIFT-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [3:0]            setup_cnt_q, setup_cnt_d;
    logic                  done_q, done_d;

    logic start_acc, capture, drain_acc;
    logic cap_ok, out_valid, at_row_end, at_tile_end;
    pix_t cap_pix, out_pix;

    assign at_row_end  = (ox_q == OFS_MAX);
    assign at_tile_end = at_row_end && (oy_q == OFS_MAX);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETUP;
            ST_SETUP:  if (setup_cnt_q == SETUP_LAST) state_d = ST_WALK;
            ST_WALK: begin
                if (cap_ok && at_row_end) state_d = at_tile_end ? ST_DRAIN : ST_SETTLE;
            end
            // The interpolator's y term is registered: one idle cycle after a row change.
            ST_SETTLE: state_d = ST_WALK;
            ST_DRAIN:  if (out_valid && pix_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        setup     = (state_q == ST_SETUP);
        busy      = (state_q != ST_IDLE);
        start_acc = (state_q == ST_IDLE) && start;
        capture   = (state_q == ST_WALK) && cap_ok;
        drain_acc = (state_q == ST_DRAIN) && out_valid && pix_ready;
    end

    always_comb begin
        tile_x_d    = tile_x_q;
        tile_y_d    = tile_y_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        setup_cnt_d = setup_cnt_q;
        done_d      = drain_acc;
        if (start_acc) begin
            tile_x_d    = tile_x;
            tile_y_d    = tile_y;
            ox_d        = '0;
            oy_d        = '0;
            setup_cnt_d = '0;
        end
        if (state_q == ST_SETUP) setup_cnt_d = setup_cnt_q + 4'd1;
        // Coordinates stay on (31,31) after the final capture; 5-bit wrap resets ox at row end.
        if (capture && !at_tile_end) begin
            ox_d = ox_q + 1'b1;
            if (at_row_end) oy_d = oy_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            setup_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            tile_x_q    <= tile_x_d;
            tile_y_q    <= tile_y_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            setup_cnt_q <= setup_cnt_d;
            done_q      <= done_d;
        end
    end

    assign x_ps = {tile_x_q, ox_q};
    assign y_ps = {tile_y_q, oy_q};

    always_comb begin
        cap_pix.x    = x_ps;
        cap_pix.y    = y_ps;
        cap_pix.z    = interp_in;
        cap_pix.last = at_tile_end;
    end

    pvr_pix_outreg u_outreg (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_i   (capture),
        .data_i   (cap_pix),
        .cap_ok_o (cap_ok),
        .valid_o  (out_valid),
        .ready_i  (pix_ready),
        .data_o   (out_pix)
    );

    assign pix_valid = out_valid;
    assign pix_x     = out_pix.x;
    assign pix_y     = out_pix.y;
    assign pix_z     = out_pix.z;
    assign pix_last  = out_pix.last;
    assign done      = done_q;

`ifdef PVR_TILE_WALKER_PERF_EN
    logic [10:0] perf_pix_q, perf_pix_d;
    logic [15:0] perf_stall_q, perf_stall_d;
    logic        stall_cyc;

    assign stall_cyc = ((state_q == ST_WALK) || (state_q == ST_DRAIN)) && out_valid && !pix_ready;

    always_comb begin
        perf_pix_d   = perf_pix_q;
        perf_stall_d = perf_stall_q;
        if (start_acc) begin
            perf_pix_d   = '0;
            perf_stall_d = '0;
        end else begin
            if (out_valid && pix_ready) perf_pix_d = perf_pix_q + 11'd1;
            if (stall_cyc && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_pix_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_pix_q   <= perf_pix_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_pix   = perf_pix_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
